// File: rtl/fdc_wb_cmd_master_if.sv
// Wishbone classic bus bundle between fdc_wb_cmd_master (master) and the u765 FDC port (slave).
interface fdc_wb_cmd_master_if;
  logic       wb_cyc_o;
  logic       wb_stb_o;
  logic       wb_we_o;
  logic [2:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/fdc_wb_cmd_master.sv
// Wishbone initiator running the uPD765 MSR handshake for a command/result byte stream.
// Optional FDC_WB_POLL_GAP_EN: insert POLL_GAP idle cycles after every MSR poll without RQM.
//
// state    | meaning
// S_IDLE   | waiting for the first command byte
// S_POLL   | reading the MSR and dispatching on RQM/DIO/EXM/CB
// S_GAP    | idle spacing between unsuccessful polls (gap build only)
// S_WRITE  | taking one byte from the cmd stream and writing it to the data register
// S_READ   | flushing the hold buffer, then reading one byte from the data register
// S_FINISH | flushing the final byte with res_last, then signalling done
module fdc_wb_cmd_master #(
  parameter logic [2:0]  MSR_ADR      = 3'b000,
  parameter logic [2:0]  DATA_ADR     = 3'b001,
  parameter int unsigned POLL_TIMEOUT = 65535,
  parameter int unsigned POLL_GAP     = 15
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_ni,
  fdc_wb_cmd_master_if.master         wb,
  input  logic [7:0]                  cmd_data,
  input  logic                        cmd_valid,
  input  logic                        cmd_last,
  output logic                        cmd_ready,
  output logic [7:0]                  res_data,
  output logic                        res_exm,
  output logic                        res_last,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int unsigned PCW = $clog2(POLL_TIMEOUT + 1);
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_TIMEOUT - 1);

  if (POLL_TIMEOUT < 1 || POLL_GAP < 1) begin : g_param_check
    $error("fdc_wb_cmd_master: POLL_TIMEOUT and POLL_GAP must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL,
    S_GAP,
    S_WRITE,
    S_READ,
    S_FINISH
  } state_e;

  state_e         state_q, state_d;
  logic           cyc_q, cyc_d;
  logic           we_q, we_d;
  logic [2:0]     adr_q, adr_d;
  logic [7:0]     wdat_q, wdat_d;
  logic           wr_last_q, wr_last_d;
  logic [PCW-1:0] poll_cnt_q, poll_cnt_d;
  logic           res_phase_q, res_phase_d;
  logic           exm_q, exm_d;
  logic           hold_full_q, hold_full_d;
  logic [7:0]     hold_dat_q, hold_dat_d;
  logic           hold_exm_q, hold_exm_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

`ifdef FDC_WB_POLL_GAP_EN
  localparam int unsigned GCW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GCW-1:0] GAP_LOAD = GCW'(POLL_GAP - 1);
  logic [GCW-1:0] gap_cnt_q, gap_cnt_d;
`endif

  logic ack;
  logic msr_rqm, msr_dio, msr_exm, msr_cb;

  assign ack     = cyc_q & wb.wb_ack_i;
  assign msr_rqm = wb.wb_dat_i[7];
  assign msr_dio = wb.wb_dat_i[6];
  assign msr_exm = wb.wb_dat_i[5];
  assign msr_cb  = wb.wb_dat_i[4];

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    wdat_d      = wdat_q;
    wr_last_d   = wr_last_q;
    poll_cnt_d  = poll_cnt_q;
    res_phase_d = res_phase_q;
    exm_d       = exm_q;
    hold_full_d = hold_full_q;
    hold_dat_d  = hold_dat_q;
    hold_exm_d  = hold_exm_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    cmd_ready   = 1'b0;
    res_valid   = 1'b0;
    res_last    = 1'b0;
`ifdef FDC_WB_POLL_GAP_EN
    gap_cnt_d   = gap_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d     = S_POLL;
          busy_d      = 1'b1;
          err_d       = 1'b0;
          res_phase_d = 1'b0;
          poll_cnt_d  = '0;
          hold_full_d = 1'b0;
        end
      end

      S_POLL: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = 1'b0;
          adr_d = MSR_ADR;
        end else if (ack) begin
          cyc_d = 1'b0;
          if (!msr_rqm) begin
            if (poll_cnt_q == POLL_LAST) begin
              // Controller never became ready: drop any pending result byte.
              err_d       = 1'b1;
              hold_full_d = 1'b0;
              busy_d      = 1'b0;
              done_d      = 1'b1;
              state_d     = S_IDLE;
            end else begin
              poll_cnt_d = poll_cnt_q + PCW'(1);
`ifdef FDC_WB_POLL_GAP_EN
              gap_cnt_d  = GAP_LOAD;
              state_d    = S_GAP;
`endif
            end
          end else begin
            poll_cnt_d = '0;
            exm_d      = msr_exm;
            if (msr_dio) begin
              state_d = S_READ;
            end else if (!res_phase_q || msr_exm) begin
              state_d = S_WRITE;
            end else if (!msr_cb) begin
              state_d = S_FINISH;
            end
            // RQM with CB still set and nothing to transfer: simply poll again.
          end
        end
      end

      S_GAP: begin
`ifdef FDC_WB_POLL_GAP_EN
        if (gap_cnt_q == '0) begin
          state_d = S_POLL;
        end else begin
          gap_cnt_d = gap_cnt_q - GCW'(1);
        end
`else
        state_d = S_POLL;
`endif
      end

      S_WRITE: begin
        if (!cyc_q) begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            cyc_d     = 1'b1;
            we_d      = 1'b1;
            adr_d     = DATA_ADR;
            wdat_d    = cmd_data;
            wr_last_d = cmd_last;
          end
        end else if (ack) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          state_d = S_POLL;
          if (wr_last_q) begin
            res_phase_d = 1'b1;
          end
        end
      end

      S_READ: begin
        if (!cyc_q) begin
          if (hold_full_q) begin
            res_valid = 1'b1;
            if (res_ready) begin
              hold_full_d = 1'b0;
            end
          end else begin
            cyc_d = 1'b1;
            we_d  = 1'b0;
            adr_d = DATA_ADR;
          end
        end else if (ack) begin
          cyc_d       = 1'b0;
          hold_full_d = 1'b1;
          hold_dat_d  = wb.wb_dat_i;
          hold_exm_d  = exm_q;
          state_d     = S_POLL;
        end
      end

      S_FINISH: begin
        // The held byte is only known to be the last one once the MSR says so.
        if (hold_full_q) begin
          res_valid = 1'b1;
          res_last  = 1'b1;
          if (res_ready) begin
            hold_full_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            state_d     = S_IDLE;
          end
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cyc_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= S_IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      wdat_q      <= '0;
      wr_last_q   <= 1'b0;
      poll_cnt_q  <= '0;
      res_phase_q <= 1'b0;
      exm_q       <= 1'b0;
      hold_full_q <= 1'b0;
      hold_dat_q  <= '0;
      hold_exm_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      wdat_q      <= wdat_d;
      wr_last_q   <= wr_last_d;
      poll_cnt_q  <= poll_cnt_d;
      res_phase_q <= res_phase_d;
      exm_q       <= exm_d;
      hold_full_q <= hold_full_d;
      hold_dat_q  <= hold_dat_d;
      hold_exm_q  <= hold_exm_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

`ifdef FDC_WB_POLL_GAP_EN
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      gap_cnt_q <= '0;
    end else begin
      gap_cnt_q <= gap_cnt_d;
    end
  end
`endif

  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = cyc_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = wdat_q;

  assign res_data = hold_dat_q;
  assign res_exm  = hold_exm_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_fdc_wb_cmd_master.sv
// Directed bench for fdc_wb_cmd_master: scripted FDC slave, result consumer and vector table.
module tb_fdc_wb_cmd_master;

`ifdef FDC_WB_POLL_GAP_EN
  localparam int GAP_MIN = 4;
`else
  localparam int GAP_MIN = 1;
`endif

  typedef struct packed {
    int               ncmd;
    logic [3:0][7:0]  cmd;
    logic [3:0]       cmd_last;
    int               nmsr;
    logic [15:0][7:0] msr;
    logic [15:0][7:0] rd;
    int               nres;
    logic [11:0][9:0] res;        // {exm, last, data}
    logic             exp_err;
    int               exp_msr_reads;
    int               ack_lat;
    logic             stall;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       cmd_last = 1'b0;
  logic       cmd_ready;
  logic [7:0] res_data;
  logic       res_exm, res_last, res_valid;
  logic       res_ready = 1'b1;
  logic       busy, done, err;

  fdc_wb_cmd_master_if bus ();

  fdc_wb_cmd_master #(
    .MSR_ADR(3'b000), .DATA_ADR(3'b001), .POLL_TIMEOUT(8), .POLL_GAP(4)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wb       (bus),
    .cmd_data (cmd_data),
    .cmd_valid(cmd_valid),
    .cmd_last (cmd_last),
    .cmd_ready(cmd_ready),
    .res_data (res_data),
    .res_exm  (res_exm),
    .res_last (res_last),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scripted FDC slave
  logic [7:0] msr_arr[16];
  logic [7:0] rd_arr[16];
  int         nmsr = 1;
  int         msr_idx = 0, rd_idx = 0, msr_reads = 0;
  logic [7:0] wr_log[16];
  int         wr_n = 0;
  int         slave_lat = 0;
  int         wcnt = 0, idle_cnt = 100;
  bit         in_acc = 0, last_rqm0 = 0;
  logic       s_we;
  logic [2:0] s_adr;
  logic [7:0] s_dat;

  initial begin
    bus.wb_ack_i = 1'b0;
    bus.wb_dat_i = 8'h00;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      bus.wb_ack_i = 1'b0;
      in_acc = 0;
      wcnt = 0;
      idle_cnt = 100;
      last_rqm0 = 0;
    end else if (bus.wb_ack_i) begin
      bus.wb_ack_i = 1'b0;
      in_acc = 0;
      chk("cyc_drop_after_ack", {31'd0, bus.wb_cyc_o}, 32'd0);
      idle_cnt = bus.wb_cyc_o ? 0 : 1;
    end else if (!bus.wb_cyc_o) begin
      idle_cnt++;
      in_acc = 0;
    end else begin
      if (!in_acc) begin
        in_acc = 1;
        wcnt = 0;
        chk(last_rqm0 ? "poll_gap_idle" : "idle_before_access",
            {31'd0, idle_cnt >= (last_rqm0 ? GAP_MIN : 1)}, 32'd1);
        last_rqm0 = 0;
        s_we  = bus.wb_we_o;
        s_adr = bus.wb_adr_o;
        s_dat = bus.wb_dat_o;
      end
      if (wcnt >= slave_lat) begin
        chk("bus_held_until_ack", {19'd0, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o},
            {19'd0, 1'b1, s_we, s_adr, s_dat});
        bus.wb_ack_i = 1'b1;
        if (bus.wb_we_o) begin
          if (wr_n < 16) wr_log[wr_n] = bus.wb_dat_o;
          wr_n++;
          chk("write_adr", {29'd0, bus.wb_adr_o}, 32'd1);
        end else if (bus.wb_adr_o == 3'd0) begin
          bus.wb_dat_i = msr_arr[(msr_idx < nmsr) ? msr_idx : nmsr - 1];
          last_rqm0 = !bus.wb_dat_i[7];
          msr_idx++;
          msr_reads++;
        end else begin
          chk("read_adr", {29'd0, bus.wb_adr_o}, 32'd1);
          bus.wb_dat_i = rd_arr[rd_idx % 16];
          rd_idx++;
        end
      end else begin
        wcnt++;
      end
    end
  end

  // Result consumer with optional 20-cycle stall on the first presented byte
  logic [9:0] got_res[16];
  int         got_n = 0;
  bit         stall_pending = 0;
  int         stalling = 0, stall_bad = 0, stall_bus = 0;
  logic [7:0] held;

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_pending && res_valid) begin
        stall_pending = 0;
        stalling = 20;
        stall_bad = 0;
        stall_bus = 0;
        held = res_data;
      end
      if (stalling > 0) begin
        res_ready = 1'b0;
        if (res_data !== held || !res_valid) stall_bad++;
        if (bus.wb_cyc_o) stall_bus++;
        stalling--;
        if (stalling == 0) begin
          chk("stall_res_data_stable", stall_bad, 0);
          chk("stall_no_bus_cycle", stall_bus, 0);
        end
      end else begin
        res_ready = 1'b1;
      end
      if (res_valid && res_ready) begin
        if (got_n < 16) got_res[got_n] = {res_exm, res_last, res_data};
        got_n++;
      end
    end
  end

  // Done monitor
  int   done_cnt = 0;
  logic err_at_done, busy_at_done;
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      err_at_done = err;
      busy_at_done = busy;
    end
  end

  vec_t vecs[6];

  task automatic send_byte(input logic [7:0] b, input logic l);
    int n;
    cmd_data = b;
    cmd_last = l;
    cmd_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_byte_accepted", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_last = 1'b0;
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    int n;
    v = vecs[k];
    for (int i = 0; i < 16; i++) begin
      msr_arr[i] = v.msr[i];
      rd_arr[i]  = v.rd[i];
    end
    nmsr = v.nmsr;
    msr_idx = 0; rd_idx = 0; msr_reads = 0; wr_n = 0; got_n = 0; done_cnt = 0;
    slave_lat = v.ack_lat;
    stall_pending = v.stall;
    @(negedge clk);
    for (int i = 0; i < v.ncmd; i++) send_byte(v.cmd[i], v.cmd_last[i]);
    n = 0;
    while (done_cnt == 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    chk($sformatf("v%0d_done_pulses", k), done_cnt, 1);
    chk($sformatf("v%0d_err", k), {31'd0, err_at_done}, {31'd0, v.exp_err});
    chk($sformatf("v%0d_busy_at_done", k), {31'd0, busy_at_done}, 32'd0);
    chk($sformatf("v%0d_writes", k), wr_n, v.ncmd);
    for (int i = 0; i < v.ncmd && i < wr_n; i++)
      chk($sformatf("v%0d_wr%0d", k, i), {24'd0, wr_log[i]}, {24'd0, v.cmd[i]});
    chk($sformatf("v%0d_results", k), got_n, v.nres);
    for (int i = 0; i < v.nres && i < got_n; i++)
      chk($sformatf("v%0d_res%0d", k, i), {22'd0, got_res[i]}, {22'd0, v.res[i]});
    chk($sformatf("v%0d_msr_reads", k), msr_reads, v.exp_msr_reads);
  endtask

  initial begin
    for (int k = 0; k < 6; k++) vecs[k] = '0;
    // Specify: three bytes, zero result bytes
    vecs[0].ncmd = 3; vecs[0].cmd[0] = 8'h03; vecs[0].cmd[1] = 8'hDF; vecs[0].cmd[2] = 8'h02;
    vecs[0].cmd_last = 4'b0100; vecs[0].nmsr = 4;
    for (int i = 0; i < 4; i++) vecs[0].msr[i] = 8'h80;
    vecs[0].exp_msr_reads = 4;
    // Sense Interrupt: two result bytes
    vecs[1].ncmd = 1; vecs[1].cmd[0] = 8'h08; vecs[1].cmd_last = 4'b0001; vecs[1].nmsr = 4;
    vecs[1].msr[0] = 8'h80; vecs[1].msr[1] = 8'hD0; vecs[1].msr[2] = 8'hD0; vecs[1].msr[3] = 8'h80;
    vecs[1].rd[0] = 8'h20; vecs[1].rd[1] = 8'h00;
    vecs[1].nres = 2; vecs[1].res[0] = {2'b00, 8'h20}; vecs[1].res[1] = {2'b01, 8'h00};
    vecs[1].exp_msr_reads = 4;
    // Execution read: 3 EXM bytes then 7 result bytes
    vecs[2].ncmd = 1; vecs[2].cmd[0] = 8'h46; vecs[2].cmd_last = 4'b0001; vecs[2].nmsr = 12;
    vecs[2].msr[0] = 8'h80;
    for (int i = 1; i <= 3; i++) vecs[2].msr[i] = 8'hF0;
    for (int i = 4; i <= 10; i++) vecs[2].msr[i] = 8'hD0;
    vecs[2].msr[11] = 8'h80;
    for (int i = 0; i < 3; i++) begin
      vecs[2].rd[i] = 8'hE5;
      vecs[2].res[i] = {2'b10, 8'hE5};
    end
    vecs[2].rd[3] = 8'h40; vecs[2].rd[4] = 8'h00; vecs[2].rd[5] = 8'h00; vecs[2].rd[6] = 8'h02;
    vecs[2].rd[7] = 8'h00; vecs[2].rd[8] = 8'h01; vecs[2].rd[9] = 8'h02;
    for (int i = 3; i < 10; i++) vecs[2].res[i] = {2'b00, vecs[2].rd[i]};
    vecs[2].res[9] = {2'b01, 8'h02};
    vecs[2].nres = 10; vecs[2].exp_msr_reads = 12;
    // Timeout: MSR stuck at 0x00 after the command byte
    vecs[3].ncmd = 1; vecs[3].cmd[0] = 8'h08; vecs[3].cmd_last = 4'b0001; vecs[3].nmsr = 2;
    vecs[3].msr[0] = 8'h80; vecs[3].msr[1] = 8'h00;
    vecs[3].exp_err = 1'b1; vecs[3].exp_msr_reads = 9;
    // Sense Interrupt with slow acks, RQM=0 polls and result backpressure
    vecs[4].ncmd = 1; vecs[4].cmd[0] = 8'h08; vecs[4].cmd_last = 4'b0001; vecs[4].nmsr = 6;
    vecs[4].msr[0] = 8'h00; vecs[4].msr[1] = 8'h80; vecs[4].msr[2] = 8'h00;
    vecs[4].msr[3] = 8'hD0; vecs[4].msr[4] = 8'hD0; vecs[4].msr[5] = 8'h80;
    vecs[4].rd[0] = 8'h20; vecs[4].rd[1] = 8'h00;
    vecs[4].nres = 2; vecs[4].res[0] = {2'b00, 8'h20}; vecs[4].res[1] = {2'b01, 8'h00};
    vecs[4].exp_msr_reads = 6; vecs[4].ack_lat = 3; vecs[4].stall = 1'b1;
    // Execution write: bytes after cmd_last go out while MSR shows EXM with DIO=0
    vecs[5].ncmd = 3; vecs[5].cmd[0] = 8'h45; vecs[5].cmd[1] = 8'h11; vecs[5].cmd[2] = 8'h22;
    vecs[5].cmd_last = 4'b0001; vecs[5].nmsr = 4;
    vecs[5].msr[0] = 8'h80; vecs[5].msr[1] = 8'hA0; vecs[5].msr[2] = 8'hA0; vecs[5].msr[3] = 8'h80;
    vecs[5].exp_msr_reads = 4;

    repeat (3) @(negedge clk);
    chk("rst_wb", {28'd0, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, |bus.wb_adr_o}, 32'd0);
    chk("rst_wb_dat", {24'd0, bus.wb_dat_o}, 32'd0);
    chk("rst_outputs", {26'd0, cmd_ready, res_valid, res_last, res_exm, busy, done, err}, 32'd0);
    chk("rst_res_data", {24'd0, res_data}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      run_vec(k);
      if (k == 3) begin
        chk("err_sticky", {31'd0, err}, 32'd1);
        chk("busy_after_timeout", {31'd0, busy}, 32'd0);
      end
    end

    // Reset in the middle of a stalled Wishbone access
    slave_lat = 100000;
    cmd_data = 8'h08; cmd_last = 1'b1; cmd_valid = 1'b1;
    for (int n = 0; n < 100 && !bus.wb_cyc_o; n++) @(negedge clk);
    chk("midrst_cyc_active", {31'd0, bus.wb_cyc_o}, 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_cyc_stb_drop", {30'd0, bus.wb_cyc_o, bus.wb_stb_o}, 32'd0);
    chk("midrst_busy_valid", {30'd0, busy, res_valid}, 32'd0);
    cmd_valid = 1'b0; cmd_last = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_vec(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fdc_wb_cmd_master.md
Name: fdc_wb_cmd_master

Overview:
- Wishbone classic initiator that drives the u765 FDC Wishbone port on behalf of a CPU-less sequencer or test harness.
- Accepts a command-byte stream and runs the uPD765 MSR handshake:
  - polls the main status register (MSR),
  - writes command and execution bytes,
  - reads execution and result bytes.
- Returns read bytes on a result stream and flags end of operation.
- Sits between a boot/loader sequencer and the FDC Wishbone slave.

Parameters:
MSR_ADR, 3'b000, Wishbone address of the MSR (a0=0)
DATA_ADR, 3'b001, Wishbone address of the data register (a0=1)
POLL_TIMEOUT, 65535, max consecutive MSR polls without RQM before abort
POLL_GAP, 15, idle cycles between unsuccessful polls (only with FDC_WB_POLL_GAP_EN)

Ports:
wb_clk_i  in  1  clock
wb_rst_ni  in  1  asynchronous active-low reset
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  write enable
wb_adr_o  out  3  address
wb_dat_o  out  8  write data
wb_dat_i  in  8  read data, valid with ack
wb_ack_i  in  1  ack
cmd_data  in  8  command/execution-write byte
cmd_valid  in  1  cmd byte valid
cmd_last  in  1  last byte of command phase
cmd_ready  out  1  byte accepted when valid&ready
res_data  out  8  byte read from data register
res_exm  out  1  byte was read with MSR.EXM=1 (execution data)
res_last  out  1  final byte of the operation
res_valid  out  1  result valid
res_ready  in  1  result consumed
busy  out  1  operation in progress
done  out  1  one-cycle pulse at operation end
err  out  1  sticky timeout flag, cleared at next accepted first cmd byte

Behaviour:
- Reset: every output low; wb_adr_o=0; wb_dat_o=0; FSM in IDLE.
- Wishbone access:
  - cyc/stb/we/adr/dat are asserted together and held until the cycle where wb_ack_i=1.
  - wb_dat_i is captured on that edge.
  - cyc/stb drop on the next cycle. No back-to-back access: at least 1 idle cycle.
- FSM states:
  - IDLE: cmd_ready=0. cmd_valid → POLL; busy=1; err cleared.
  - POLL: read MSR_ADR; captured bits: RQM=b7, DIO=b6, EXM=b5, CB=b4.
    - RQM=0 → poll again; poll counter +1.
    - RQM=1, DIO=0, command phase → WRITE.
    - RQM=1, DIO=1 → READ.
    - RQM=1, DIO=0, result phase, EXM=1 → WRITE (execution write).
    - RQM=1, DIO=0, result phase, EXM=0, CB=0 → FINISH.
  - WRITE:
    - cmd_ready=1 for one cycle; wait for cmd_valid.
    - Write cmd_data to DATA_ADR.
    - If the byte carried cmd_last, enter result phase.
    - → POLL.
  - READ:
    - Read DATA_ADR.
    - If a byte is held in the 1-deep hold buffer, present it on res_* (res_last=0) and stall until res_ready.
    - Store the new byte and its EXM bit in the hold buffer.
    - → POLL.
  - FINISH:
    - If the hold buffer is full, present it with res_last=1 and wait for res_ready.
    - Pulse done; busy=0 → IDLE.
    - Zero-result commands (Specify, Seek) produce done with no res_valid.
- Poll counter:
  - Reset to 0 on any MSR read with RQM=1.
  - Reaching POLL_TIMEOUT sets err, discards the hold buffer, pulses done → IDLE. No res_valid is issued.
- res_* and cmd_ready obey valid/ready: res_data is stable while res_valid=1 and res_ready=0.
- If cmd_valid=0 in WRITE, the FSM waits indefinitely (no timeout).
- Reset mid-access: cyc/stb drop asynchronously; the hold buffer is cleared.

Optional Feature:
FDC_WB_POLL_GAP_EN
- Defined: after an MSR read with RQM=0, wait POLL_GAP idle cycles (cyc=0) before the next poll. The timeout counts polls, not cycles.
- Undefined: the next poll starts after the mandatory 1 idle cycle.

Test Plan:
- Specify 0x03,0xDF,0x02 (last on 3rd), MSR sequence 0x80,0x80,0x80,0x80 → three writes to adr 1 with those bytes, done pulse, no res_valid, err=0.
- Sense Interrupt 0x08; MSR 0x80 then 0xD0,0xD0,0x80; data 0x20,0x00 → res 0x20 (last=0), 0x00 (last=1), res_exm=0, done after second accept.
- Result backpressure: hold res_ready=0 for 20 cycles mid-result → res_data stable, no Wishbone cycle after the held read, completion resumes on res_ready=1.
- Execution read: MSR 0xF0 with data 0xE5 for 3 bytes, then 7 result bytes at 0xD0 → 10 bytes out, first 3 with res_exm=1, last flagged only on 10th.
- Timeout with POLL_TIMEOUT=8: MSR fixed 0x00 → exactly 8 MSR reads, err=1, done pulse, busy=0; next command clears err.
- Ack latency: slave acks 3 cycles after stb → stb held until ack, dropped next cycle, captured data correct. With FDC_WB_POLL_GAP_EN and POLL_GAP=4, check ≥4 idle cycles between RQM=0 polls.
